// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the execute-path operand selectors.
//   - XLEN_DEFAULT / SHAMT_W_DEFAULT : default datapath and shift-amount widths
//   - SEL_*                          : operand-B select codes carried on Senal
//   - skid_state_e                   : occupancy states of the output skid buffer
// No ports; imported by the interface, the decoder and the pipeline top.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    // Operand-B select encodings
    localparam logic [2:0] SEL_REG   = 3'b000;
    localparam logic [2:0] SEL_I     = 3'b001;
    localparam logic [2:0] SEL_S     = 3'b010;
    localparam logic [2:0] SEL_B     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_J     = 3'b101;
    localparam logic [2:0] SEL_SHAMT = 3'b110;
    localparam logic [2:0] SEL_ZERO  = 3'b111;

    // EMPTY: nothing buffered; ONE: main register holds an item;
    // FULL: main and skid registers both hold items
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/mux_b_imm_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_b_imm_pipe_if
// Bundles the operand-B selector's upstream (decode side) and downstream
// (ALU side) valid/ready channels.
//   Instruccion [31:0]     instruction word
//   resultado   [XLEN-1:0] rs2 register value
//   Senal       [2:0]      operand select code
//   in_valid / in_ready    upstream handshake
//   Salida      [XLEN-1:0] selected operand B
//   out_valid / out_ready  downstream handshake
// Modports: master = the environment around the block, slave = the block.
// -----------------------------------------------------------------------------
interface mux_b_imm_pipe_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic [31:0]     Instruccion;
    logic [XLEN-1:0] resultado;
    logic [2:0]      Senal;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] Salida;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output Instruccion,
        output resultado,
        output Senal,
        output in_valid,
        input  in_ready,
        input  Salida,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  Instruccion,
        input  resultado,
        input  Senal,
        input  in_valid,
        output in_ready,
        output Salida,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational operand-B selector: extracts the RV32I/RV64I immediate
// chosen by Senal from Instruccion and sign-extends it to XLEN, or passes the
// register operand through.
//   Instruccion [31:0]     instruction word
//   resultado   [XLEN-1:0] register operand
//   Senal       [2:0]      select code (SEL_* in riscv_pkg)
//   value       [XLEN-1:0] selected, extended operand
// -----------------------------------------------------------------------------
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic [31:0]     Instruccion,
    input  logic [XLEN-1:0] resultado,
    input  logic [2:0]      Senal,
    output logic [XLEN-1:0] value
);

    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [12:0] imm_b;
    logic [31:0] imm_u;
    logic [20:0] imm_j;
    logic        unused_opcode;

    // Raw immediate fields; bit 31 is the MSB of every signed format, so a
    // signed cast to XLEN performs the sign extension.
    assign imm_i = Instruccion[31:20];
    assign imm_s = {Instruccion[31:25], Instruccion[11:7]};
    assign imm_b = {Instruccion[31], Instruccion[7], Instruccion[30:25],
                    Instruccion[11:8], 1'b0};
    assign imm_u = {Instruccion[31:12], 12'b0};
    assign imm_j = {Instruccion[31], Instruccion[19:12], Instruccion[20],
                    Instruccion[30:21], 1'b0};

    // The opcode field never contributes to an immediate
    assign unused_opcode = ^Instruccion[6:0];

    always_comb begin
        value = '0;
        case (Senal)
            SEL_REG:   value = resultado;
            SEL_I:     value = XLEN'($signed(imm_i));
            SEL_S:     value = XLEN'($signed(imm_s));
            SEL_B:     value = XLEN'($signed(imm_b));
            SEL_U:     value = XLEN'($signed(imm_u));
            SEL_J:     value = XLEN'($signed(imm_j));
            SEL_SHAMT: value = XLEN'(Instruccion[20 +: SHAMT_W]);
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/mux_b_imm_pipe.sv
// -----------------------------------------------------------------------------
// mux_b_imm_pipe
// Registered operand-B selector between decode and the ALU. The decoded
// operand enters a 2-entry skid buffer (main register M, skid register K) so
// upstream and downstream may stall independently at full throughput.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mux_b_imm_pipe_if.slave (Instruccion/resultado/Senal with
//          in_valid/in_ready; Salida with out_valid/out_ready)
// -----------------------------------------------------------------------------
module mux_b_imm_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_b_imm_pipe_if.slave      bus
);

    // Reject unsupported widths at elaboration time
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("mux_b_imm_pipe: XLEN must be 32 or 64");
        end
        if ((XLEN == 32 && SHAMT_W != 5) || (XLEN == 64 && SHAMT_W != 6)) begin : g_bad_shamt
            $error("mux_b_imm_pipe: SHAMT_W must be 5 for XLEN=32, 6 for XLEN=64");
        end
    endgenerate

    skid_state_e     state_q, state_d;
    logic [XLEN-1:0] m_data_q, m_data_d;
    logic [XLEN-1:0] k_data_q, k_data_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] dec_value;
    logic            accept;
    logic            consume;

    imm_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_imm_decode (
        .Instruccion (bus.Instruccion),
        .resultado   (bus.resultado),
        .Senal       (bus.Senal),
        .value       (dec_value)
    );

    // Both handshake outputs are masked during the reset cycle so that no
    // transfer can complete while buffered items are being discarded.
    // in_ready otherwise comes straight from a flop, never from out_ready.
    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = (state_q != ST_EMPTY) & ~rst;
    assign bus.Salida    = m_data_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;

    // Next-state and datapath steering. M only changes when a new item must
    // become visible, so Salida is stable while stalled and after draining.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        k_data_d = k_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    m_data_d = dec_value;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    m_data_d = dec_value;
                end else if (accept) begin
                    state_d  = ST_FULL;
                    k_data_d = dec_value;
                end else if (consume) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d  = ST_ONE;
                    m_data_d = k_data_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            m_data_q   <= '0;
            k_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            k_data_q   <= k_data_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_mux_b_imm_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_b_imm_pipe
// Self-checking bench for mux_b_imm_pipe: an XLEN=32 instance exercised with
// a decode vector table, throughput, backpressure and mid-operation reset,
// plus an XLEN=64 instance for the wide sign-extension and 6-bit shamt.
// -----------------------------------------------------------------------------
module tb_mux_b_imm_pipe;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic [2:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    mux_b_imm_pipe_if #(.XLEN(32)) bus32();
    mux_b_imm_pipe_if #(.XLEN(64)) bus64();

    mux_b_imm_pipe #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    mux_b_imm_pipe #(
        .XLEN    (64),
        .SHAMT_W (6)
    ) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the 32-bit instance starting at a negedge. The
    // handshakes are observed 1 time unit later (away from the rising edge):
    // an output consume pops the scoreboard, an accept pushes the expectation.
    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] res, input logic [2:0] sel,
                                 input logic ordy, input logic [31:0] exp,
                                 output logic accepted, output logic consumed);
        logic [31:0] want;
        bus32.in_valid    = v;
        bus32.Instruccion = ins;
        bus32.resultado   = res;
        bus32.Senal       = sel;
        bus32.out_ready   = ordy;
        #1;
        accepted = v && bus32.in_ready;
        consumed = bus32.out_valid && bus32.out_ready;
        if (consumed) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output",
                         bus32.Salida);
            end else begin
                want = exp_q.pop_front();
                checkOutput("scoreboard", 64'(bus32.Salida), 64'(want));
            end
        end
        if (accepted) exp_q.push_back(exp);
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[10];
        logic        acc;
        logic        con;
        logic [31:0] rnd;
        int          n_con;
        int          n_low;
        int          guard;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'hFFF0_0093, 32'h0000_0000, 3'b001, 32'hFFFF_FFFF};
        vecs[1] = '{32'hFFF0_0093, 32'h0000_0000, 3'b100, 32'hFFF0_0000};
        vecs[2] = '{32'hFFF0_0093, 32'h0000_0000, 3'b110, 32'h0000_001F};
        vecs[3] = '{32'hFFF0_0093, 32'hDEAD_BEEF, 3'b111, 32'h0000_0000};
        vecs[4] = '{32'h8000_0F63, 32'h0000_0000, 3'b011, 32'hFFFF_F01E};
        vecs[5] = '{32'h8000_006F, 32'h0000_0000, 3'b101, 32'hFFF0_0000};
        vecs[6] = '{32'hFE11_2E23, 32'h0000_0000, 3'b010, 32'hFFFF_FFFC};
        vecs[7] = '{32'hFFF0_0093, 32'h1234_5678, 3'b000, 32'h1234_5678};
        vecs[8] = '{32'h0050_0013, 32'h0000_0000, 3'b110, 32'h0000_0005};
        vecs[9] = '{32'h7FF0_0013, 32'h0000_0000, 3'b001, 32'h0000_07FF};

        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.Instruccion = '0; bus32.resultado = '0;
        bus32.Senal = '0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.Instruccion = '0; bus64.resultado = '0;
        bus64.Senal = '0; bus64.out_ready = 1'b0;

        // Reset state, during and right after the reset cycles
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_in_ready_during", 64'(bus32.in_ready), 64'd0);
        checkOutput("rst_out_valid_during", 64'(bus32.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready_after", 64'(bus32.in_ready), 64'd1);
        checkOutput("rst_out_valid_after", 64'(bus32.out_valid), 64'd0);
        checkOutput("rst_salida_after", 64'(bus32.Salida), 64'd0);
        @(negedge clk);

        // Decode table streamed back to back with the ALU always ready
        n_low = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].ins, vecs[i].res, vecs[i].sel, 1'b1,
                          vecs[i].exp, acc, con);
            if (!acc) n_low++;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 5) begin
            applyStimulus(1'b0, '0, '0, 3'b000, 1'b1, '0, acc, con);
            guard++;
        end
        checkOutput("decode_not_accepted", 64'(n_low), 64'd0);
        checkOutput("decode_drained", 64'(exp_q.size()), 64'd0);

        // After draining to EMPTY the last operand stays on Salida
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'hFFFF_FFFF, '1, 3'b000, 1'b1, '0, acc, con);
        end
        #1;
        checkOutput("idle_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("idle_salida_hold", 64'(bus32.Salida), 64'h7FF);
        @(negedge clk);

        // Throughput: 10 items in 10 cycles, last consumed one cycle later
        n_con = 0;
        n_low = 0;
        for (int i = 0; i < 11; i++) begin
            rnd = $urandom;
            if (i < 10) begin
                applyStimulus(1'b1, 32'h0, rnd, 3'b000, 1'b1, rnd, acc, con);
                if (!acc) n_low++;
            end else begin
                applyStimulus(1'b0, 32'h0, rnd, 3'b000, 1'b1, rnd, acc, con);
            end
            if (con) n_con++;
        end
        checkOutput("tput_consumes", 64'(n_con), 64'd10);
        checkOutput("tput_in_ready_low", 64'(n_low), 64'd0);

        // Backpressure: two accepts fill the buffer, then in_ready drops
        applyStimulus(1'b1, 32'h0, 32'd1, 3'b000, 1'b0, 32'd1, acc, con);
        applyStimulus(1'b1, 32'h0, 32'd2, 3'b000, 1'b0, 32'd2, acc, con);
        applyStimulus(1'b1, 32'h0, 32'd3, 3'b000, 1'b0, 32'd3, acc, con);
        checkOutput("bp_third_not_accepted", 64'(acc), 64'd0);
        #1;
        checkOutput("bp_in_ready_full", 64'(bus32.in_ready), 64'd0);
        checkOutput("bp_salida_hold", 64'(bus32.Salida), 64'd1);
        checkOutput("bp_out_valid_hold", 64'(bus32.out_valid), 64'd1);
        @(negedge clk);
        n_con = 0;
        for (int item = 3; item <= 4; item++) begin
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 10) begin
                applyStimulus(1'b1, 32'h0, 32'(item), 3'b000, 1'b1, 32'(item), acc, con);
                if (con) n_con++;
                guard++;
            end
            checkOutput("bp_item_accepted", 64'(acc), 64'd1);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0, acc, con);
            if (con) n_con++;
            guard++;
        end
        checkOutput("bp_consumes", 64'(n_con), 64'd4);

        // Reset while FULL: both buffered items must vanish
        applyStimulus(1'b1, 32'h0, 32'hAA, 3'b000, 1'b0, 32'hAA, acc, con);
        applyStimulus(1'b1, 32'h0, 32'hBB, 3'b000, 1'b0, 32'hBB, acc, con);
        rst = 1'b1;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus32.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("post_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("post_rst_salida", 64'(bus32.Salida), 64'd0);
        checkOutput("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0, acc, con);
        end
        applyStimulus(1'b1, 32'h0, 32'h55, 3'b000, 1'b1, 32'h55, acc, con);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0, acc, con);
        checkOutput("post_rst_item_out", 64'(con), 64'd1);
        checkOutput("final_drained", 64'(exp_q.size()), 64'd0);

        // XLEN=64 instance: wide U sign-extension, 6-bit shamt, wide I
        bus64.out_ready   = 1'b1;
        bus64.in_valid    = 1'b1;
        bus64.Instruccion = 32'h8000_0037;
        bus64.Senal       = 3'b100;
        #1;
        checkOutput("x64_in_ready", 64'(bus64.in_ready), 64'd1);
        @(negedge clk);
        bus64.Instruccion = 32'h03F0_0013;
        bus64.Senal       = 3'b110;
        #1;
        checkOutput("x64_u_valid", 64'(bus64.out_valid), 64'd1);
        checkOutput("x64_u", bus64.Salida, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        bus64.Instruccion = 32'hFFF0_0093;
        bus64.Senal       = 3'b001;
        #1;
        checkOutput("x64_shamt", bus64.Salida, 64'h0000_0000_0000_003F);
        @(negedge clk);
        bus64.in_valid = 1'b0;
        #1;
        checkOutput("x64_i", bus64.Salida, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        #1;
        checkOutput("x64_drained", 64'(bus64.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_b_imm_pipe.md
Name: mux_b_imm_pipe

Overview:
- Parametrised successor to the operand-B selector for the RISC-V execute path.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J, shamt) or passes the register operand through.
- Sign-extends the result to XLEN and delivers it through a registered valid/ready stage with a 2-entry skid buffer, so decode and ALU can stall independently.
- Sits between the register-file/decode stage and the ALU operand-B input.

Parameters:
- XLEN, 32, width of operand and result; legal values are 32 and 64.
- SHAMT_W, 5, shift-amount width; use 5 for XLEN=32 and 6 for XLEN=64.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- Instruccion  in  32  instruction word
- resultado  in  XLEN  register operand (rs2 value)
- Senal  in  3  operand select, encoded as:
  - 000 register
  - 001 I
  - 010 S
  - 011 B
  - 100 U
  - 101 J
  - 110 shamt
  - 111 zero
- in_valid  in  1  upstream presents Instruccion/resultado/Senal
- in_ready  out  1  block can accept this cycle
- Salida  out  XLEN  selected operand B
- out_valid  out  1  Salida is valid
- out_ready  in  1  downstream consumes Salida this cycle

Behaviour:
- Clocking and reset: one clock domain, clk; rst is synchronous and active-high.
- Immediate decode (combinational, before the registers). Let "sx" mean sign-extend from Instruccion[31] to XLEN.
  - 000: resultado.
  - 001: sx(Instruccion[31:20]).
  - 010: sx({Instruccion[31:25], Instruccion[11:7]}).
  - 011: sx({Instruccion[31], Instruccion[7], Instruccion[30:25], Instruccion[11:8], 1'b0}).
  - 100: sx({Instruccion[31:12], 12'b0}). For XLEN=64 the upper bits copy bit 31.
  - 101: sx({Instruccion[31], Instruccion[19:12], Instruccion[20], Instruccion[30:21], 1'b0}).
  - 110: zero-extended Instruccion[20 +: SHAMT_W].
  - 111: all zeros. The output is never driven to high-Z.
- Handshake rules:
  - An accept happens when in_valid && in_ready.
  - A consume happens when out_valid && out_ready.
  - Latency from accept to out_valid is exactly 1 cycle.
  - Full throughput is 1 item/cycle when out_ready is held high.
- Storage: main register M (drives Salida/out_valid) and skid register K.
- State machine:
  - EMPTY: M and K invalid.
    - accept -> ONE, M loads.
  - ONE: M valid.
    - accept && consume -> ONE, M reloads.
    - accept && !consume -> FULL, K loads.
    - consume && !accept -> EMPTY.
  - FULL: M and K valid; in_ready=0.
    - consume -> ONE, M<=K.
- in_ready is a registered output: 1 in EMPTY/ONE, 0 in FULL. No combinational path from out_ready to in_ready.
- Ordering: items leave in accept order. No drop, no duplication.
- Salida holds its value while out_valid && !out_ready.
- Salida must not change while out_valid is low once it has been consumed; after consume-to-EMPTY it holds its last value.
- Reset values: out_valid=0, Salida=0, in_ready=0 during the rst cycle, 1 from the first cycle after rst deasserts. State EMPTY, K cleared.
- Reset mid-operation: all buffered items are discarded; no output handshake completes in the rst cycle.
- in_valid while in_ready=0: ignored. Upstream holds its data.
- Parameter legality: XLEN outside {32,64} is a compile-time error via a generate-time check.

Decomposition:
- Shared package riscv_pkg holds:
  - Senal encodings as localparams: SEL_REG, SEL_I, SEL_S, SEL_B, SEL_U, SEL_J, SEL_SHAMT, SEL_ZERO.
  - XLEN default.
- Sub-module imm_decode: purely combinational, (Instruccion, resultado, Senal) -> XLEN value; reusable by the branch unit.
- Top mux_b_imm_pipe instantiates imm_decode and holds the skid FSM.

Test Plan:
- Decode sweep, out_ready=1, XLEN=32, Instruccion=32'hFFF0_0093 -> expected Salida 1 cycle after accept:
  - Senal=001 -> 32'hFFFF_FFFF.
  - Senal=100 -> 32'hFFF0_0000.
  - Senal=110 -> 32'h0000_001F.
  - Senal=111 -> 32'h0000_0000.
- B/J/S formats:
  - Instruccion=32'h8000_0F63, Senal=011 -> 32'hFFFF_F01E.
  - Instruccion=32'h8000_006F, Senal=101 -> 32'hFFF0_0000.
  - Instruccion=32'hFE11_2E23, Senal=010 -> 32'hFFFF_FFFC.
- Backpressure: stream 4 items with Senal=000, resultado=1,2,3,4; hold out_ready=0 for 3 cycles:
  - in_ready drops after the 2nd accept.
  - Salida holds 1.
  - Release out_ready: outputs 1,2,3,4 in order, none lost.
- Throughput: in_valid=out_ready=1 for 10 cycles -> 10 consumes in 11 cycles; in_ready never 0.
- Reset mid-operation: FULL state, assert rst 1 cycle:
  - Next cycle out_valid=0, Salida=0, in_ready=1.
  - The old items never appear.
- XLEN=64 build: Instruccion=32'h8000_0037, Senal=100 -> Salida=64'hFFFF_FFFF_8000_0000; SHAMT_W=6 with Instruccion[25:20]=6'h3F, Senal=110 -> 64'h3F.
